// File: rtl/oscope_pkg.sv
// Shared widths and read-controller state encoding for the capture read path.
// No logic; latency and backpressure not applicable.
package oscope_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO; head visible the cycle after write, pop on rd.
// Latency 1 write-to-empty-deassert; writes when full are dropped, flush empties in one cycle.
module sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_wr;
    logic              do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_wr    = wr && !full && !flush;
        do_rd    = rd && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/capture_buffer_reader.sv
// Strided, wrapping read-out of the capture RAM onto a valid/ready sample stream.
// First valid READ_LATENCY+2 cycles after start; reads stall when in-flight + buffered words reach FIFO_DEPTH.
module capture_buffer_reader
    import oscope_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MEM_DEPTH    = 131072,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic [5:0]        step,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_cs,
    output logic              mem_clk_en,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              sample_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] FIFO_LIM = ADDR_W'(FIFO_DEPTH);

    rd_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [5:0]              step_q, step_d;
    logic [ADDR_W-1:0]       num_q, num_d;
    logic [ADDR_W-1:0]       issued_q, issued_d;
    logic [ADDR_W-1:0]       delivered_q, delivered_d;
    logic [READ_LATENCY-1:0] lat_q, lat_d;

    logic              rd_issue;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic              handshake;
    logic              last_word;
    logic              credit_ok;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W:0]   addr_wrap;

    // issued - delivered counts words both in flight and sitting in the FIFO.
    assign credit_ok = (issued_q - delivered_q) < FIFO_LIM;
    assign addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(step_q);
    assign addr_wrap = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;
    assign handshake = sample_valid && sample_ready;
    assign last_word = (delivered_q == (num_q - ADDR_W'(1)));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        step_d      = step_q;
        num_d       = num_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        rd_issue    = 1'b0;
        fifo_flush  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    num_d       = num_samples;
                    step_d      = (step == 6'd0) ? 6'd1 : step;
                    addr_d      = ({1'b0, start_addr} >= DEPTH_W) ? '0 : start_addr;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (num_samples == '0) ? RD_DONE : RD_READ;
                end
            end
            RD_READ: begin
                busy = 1'b1;
                if (abort) begin
                    fifo_flush = 1'b1;
                    addr_d     = '0;
                    state_d    = RD_IDLE;
                end else begin
                    if (credit_ok) begin
                        rd_issue = 1'b1;
                        addr_d   = addr_wrap[ADDR_W-1:0];
                        issued_d = issued_q + ADDR_W'(1);
                        if (issued_q == (num_q - ADDR_W'(1))) state_d = RD_DRAIN;
                    end
                    if (handshake) delivered_d = delivered_q + ADDR_W'(1);
                end
            end
            RD_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    fifo_flush = 1'b1;
                    addr_d     = '0;
                    state_d    = RD_IDLE;
                end else if (handshake) begin
                    delivered_d = delivered_q + ADDR_W'(1);
                    if (last_word) state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                done    = 1'b1;
                state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase

        // Clearing the delay line drops words still returning from an aborted read-out.
        lat_d = fifo_flush ? '0 : ((lat_q << 1) | READ_LATENCY'(rd_issue));
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            step_q      <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            lat_q       <= lat_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_read    = rd_issue;
    assign mem_cs      = rd_issue;
    assign mem_clk_en  = (state_q != RD_IDLE);
    assign sample_valid = !fifo_empty;
    assign sample_last  = sample_valid && last_word;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_50),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr      (lat_q[READ_LATENCY-1] && !fifo_full),
        .wr_data (mem_read_data),
        .rd      (sample_ready),
        .rd_data (sample_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
